// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and action selection for the pipeline stage registers.
// Optional feature macro: PIPE_STAGE_STATS_EN (stall/bubble statistics counters).
package pipe_stage_reg_pkg;

  localparam int unsigned CTRL_LEN     = 32;
  localparam int unsigned TNEW_LSB_DEF = 8;
  localparam int unsigned TNEW_W_DEF   = 3;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  // One action per clock edge; encoding order carries no meaning.
  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_STALL,
    ACT_FLUSH,
    ACT_REQ
  } stage_act_e;

  // Priority: exception request, then flush, then stall, otherwise load.
  function automatic stage_act_e sel_action(input logic req, input logic flush,
                                            input logic stall);
    if (req)        return ACT_REQ;
    else if (flush) return ACT_FLUSH;
    else if (stall) return ACT_STALL;
    else            return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Saturating decrement of the Tnew field: 0 stays 0, otherwise value minus one.
module tnew_sat_dec #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  // Combinational saturating decrement.
  always_comb begin
    o_val = '0;
    if (i_val != '0) o_val = i_val - W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register (D/E/M/W) with stall, flush and
// exception-request handling, plus Tnew aging on the control word.
// Optional feature macro: PIPE_STAGE_STATS_EN adds StallCnt/BubbleCnt outputs.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W    = 160,
  parameter int unsigned CTRL_W    = CTRL_LEN,
  parameter int unsigned TNEW_LSB  = TNEW_LSB_DEF,
  parameter int unsigned TNEW_W    = TNEW_W_DEF,
  parameter bit          DECR_TNEW = 1'b1,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC    = EXC_PC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [31:0]       InsIn,
  input  logic [31:0]       PCIn,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic              BDIn,
  input  logic [4:0]        ExcIn,
  output logic [31:0]       InsOut,
  output logic [31:0]       PCOut,
  output logic [DATA_W-1:0] DataOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic              BDOut,
  output logic [4:0]        ExcOut,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       StallCnt,
  output logic [31:0]       BubbleCnt,
`endif
  output logic              ValidOut
);

  logic [31:0]       r_ins;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_bd;
  logic [4:0]        r_exc;
  logic              r_valid;

  stage_act_e        w_act;
  logic [TNEW_W-1:0] w_tnew_raw;
  logic [TNEW_W-1:0] w_tnew_dec;
  logic [TNEW_W-1:0] w_tnew_out;
  logic [CTRL_W-1:0] w_ctrl_out;

  assign w_act = sel_action(Req, Flush, Stall);

  // Stage contents: one prioritised action per edge; reset wins over all.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ins   <= '0;
      r_pc    <= RESET_PC;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_bd    <= 1'b0;
      r_exc   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (w_act)
        ACT_REQ: begin
          r_ins   <= '0;
          r_pc    <= EXC_PC;
          r_data  <= '0;
          r_ctrl  <= '0;
          r_bd    <= 1'b0;
          r_exc   <= '0;
          r_valid <= 1'b0;
        end
        ACT_FLUSH: begin
          // Bubble keeps PC/BD so a later exception still reports the right EPC.
          r_ins   <= '0;
          r_pc    <= PCIn;
          r_data  <= '0;
          r_ctrl  <= '0;
          r_bd    <= BDIn;
          r_exc   <= '0;
          r_valid <= 1'b0;
        end
        ACT_STALL: ;
        default: begin
          r_ins   <= InsIn;
          r_pc    <= PCIn;
          r_data  <= DataIn;
          r_ctrl  <= CtrlIn;
          r_bd    <= BDIn;
          r_exc   <= ExcIn;
          r_valid <= 1'b1;
        end
      endcase
    end
  end

  assign w_tnew_raw = r_ctrl[TNEW_LSB +: TNEW_W];

  tnew_sat_dec #(
    .W (TNEW_W)
  ) u_tnew_dec (
    .i_val (w_tnew_raw),
    .o_val (w_tnew_dec)
  );

  assign w_tnew_out = DECR_TNEW ? w_tnew_dec : w_tnew_raw;

  // Control word out: stored bits with only the Tnew field replaced.
  always_comb begin
    w_ctrl_out = r_ctrl;
    w_ctrl_out[TNEW_LSB +: TNEW_W] = w_tnew_out;
  end

  assign InsOut   = r_ins;
  assign PCOut    = r_pc;
  assign DataOut  = r_data;
  assign CtrlOut  = w_ctrl_out;
  assign BDOut    = r_bd;
  assign ExcOut   = r_exc;
  assign ValidOut = r_valid;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Statistics: count stall edges and bubble-inserting edges, wrapping at 2^32.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_act == ACT_STALL) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_act == ACT_FLUSH || w_act == ACT_REQ) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign StallCnt  = r_stall_cnt;
  assign BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a randomized
// phase, checked against a behavioural model of the stage contents.
module tb_pipe_stage_reg;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Req, Stall, Flush;
  logic [31:0]  InsIn, PCIn;
  logic [159:0] DataIn;
  logic [31:0]  CtrlIn;
  logic         BDIn;
  logic [4:0]   ExcIn;

  logic [31:0]  InsOut, PCOut;
  logic [159:0] DataOut;
  logic [31:0]  CtrlOut;
  logic         BDOut, ValidOut;
  logic [4:0]   ExcOut;

  logic [31:0]  rInsOut, rPCOut;
  logic [159:0] rDataOut;
  logic [31:0]  rCtrlOut;
  logic         rBDOut, rValidOut;
  logic [4:0]   rExcOut;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]  StallCnt, BubbleCnt, rStallCnt, rBubbleCnt;
`endif

  always #5 Clk = ~Clk;

  pipe_stage_reg u_dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Stall(Stall), .Flush(Flush),
    .InsIn(InsIn), .PCIn(PCIn), .DataIn(DataIn), .CtrlIn(CtrlIn),
    .BDIn(BDIn), .ExcIn(ExcIn),
    .InsOut(InsOut), .PCOut(PCOut), .DataOut(DataOut), .CtrlOut(CtrlOut),
    .BDOut(BDOut), .ExcOut(ExcOut),
`ifdef PIPE_STAGE_STATS_EN
    .StallCnt(StallCnt), .BubbleCnt(BubbleCnt),
`endif
    .ValidOut(ValidOut)
  );

  pipe_stage_reg #(
    .DECR_TNEW (1'b0)
  ) u_raw (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Stall(Stall), .Flush(Flush),
    .InsIn(InsIn), .PCIn(PCIn), .DataIn(DataIn), .CtrlIn(CtrlIn),
    .BDIn(BDIn), .ExcIn(ExcIn),
    .InsOut(rInsOut), .PCOut(rPCOut), .DataOut(rDataOut), .CtrlOut(rCtrlOut),
    .BDOut(rBDOut), .ExcOut(rExcOut),
`ifdef PIPE_STAGE_STATS_EN
    .StallCnt(rStallCnt), .BubbleCnt(rBubbleCnt),
`endif
    .ValidOut(rValidOut)
  );

  typedef struct {
    logic [31:0]  ins;
    logic [31:0]  pc;
    logic [159:0] data;
    logic [31:0]  ctrl;
    logic         bd;
    logic [4:0]   exc;
    logic         valid;
  } stage_t;

  stage_t      m;
  int unsigned m_stalls, m_bubbles;
  int unsigned n_tests, n_fail;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word: Tnew (bits 10:8) aged by one cycle, floor at zero.
  function automatic logic [31:0] exp_ctrl(input logic [31:0] c, input bit decr);
    logic [31:0] r;
    int          t;
    r = c;
    t = int'(c[10:8]);
    if (decr && t > 0) t = t - 1;
    r[10:8] = 3'(t);
    return r;
  endfunction

  task automatic model_reset();
    m = '{ins: 0, pc: 32'h0000_3000, data: 0, ctrl: 0, bd: 0, exc: 0, valid: 0};
    m_stalls  = 0;
    m_bubbles = 0;
  endtask

  // Next-state of the stage contents from the current input values.
  task automatic model_edge();
    if (Req) begin
      m = '{ins: 0, pc: 32'h0000_4180, data: 0, ctrl: 0, bd: 0, exc: 0, valid: 0};
      m_bubbles++;
    end else if (Flush) begin
      m = '{ins: 0, pc: PCIn, data: 0, ctrl: 0, bd: BDIn, exc: 0, valid: 0};
      m_bubbles++;
    end else if (Stall) begin
      m_stalls++;
    end else begin
      m = '{ins: InsIn, pc: PCIn, data: DataIn, ctrl: CtrlIn, bd: BDIn, exc: ExcIn, valid: 1};
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ins"},   InsOut,   m.ins);
    chk({tag, ".pc"},    PCOut,    m.pc);
    chk({tag, ".data"},  DataOut,  m.data);
    chk({tag, ".ctrl"},  CtrlOut,  exp_ctrl(m.ctrl, 1'b1));
    chk({tag, ".bd"},    BDOut,    m.bd);
    chk({tag, ".exc"},   ExcOut,   m.exc);
    chk({tag, ".valid"}, ValidOut, m.valid);
    chk({tag, ".raw_ctrl"},  rCtrlOut,  exp_ctrl(m.ctrl, 1'b0));
    chk({tag, ".raw_pc"},    rPCOut,    m.pc);
    chk({tag, ".raw_valid"}, rValidOut, m.valid);
    chk({tag, ".raw_ins"},   rInsOut,   m.ins);
    chk({tag, ".raw_data"},  rDataOut,  m.data);
    chk({tag, ".raw_bd"},    rBDOut,    m.bd);
    chk({tag, ".raw_exc"},   rExcOut,   m.exc);
`ifdef PIPE_STAGE_STATS_EN
    chk({tag, ".stallcnt"},  StallCnt,  m_stalls);
    chk({tag, ".bubblecnt"}, BubbleCnt, m_bubbles);
    chk({tag, ".raw_stallcnt"},  rStallCnt,  m_stalls);
    chk({tag, ".raw_bubblecnt"}, rBubbleCnt, m_bubbles);
`endif
  endtask

  task automatic rand_inputs(input logic req, input logic flush, input logic stall);
    Req    = req;
    Flush  = flush;
    Stall  = stall;
    InsIn  = $urandom;
    PCIn   = $urandom;
    DataIn = {$urandom, $urandom, $urandom, $urandom, $urandom};
    CtrlIn = $urandom;
    BDIn   = 1'($urandom_range(0, 1));
    ExcIn  = 5'($urandom_range(0, 31));
  endtask

  // One clock edge with reset low: predict, clock, sample 1 time unit later.
  task automatic step(input string tag);
    model_edge();
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset asserted from time zero, with every other control active.
    Reset = 1'b1;
    rand_inputs(1'b1, 1'b1, 1'b1);
    model_reset();
    #1;
    check_all("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      rand_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge Clk);
      #1;
      check_all("reset_held");
    end
    @(negedge Clk);
    Reset = 1'b0;

    // Load with Tnew=2, then Tnew=0.
    rand_inputs(1'b0, 1'b0, 1'b0);
    PCIn = 32'h0000_3010;
    CtrlIn[10:8] = 3'd2;
    step("load_tnew2");
    chk("load_tnew2.pc_lit",   PCOut, 32'h0000_3010);
    chk("load_tnew2.tnew_lit", CtrlOut[10:8], 3'd1);
    chk("load_tnew2.valid_lit", ValidOut, 1'b1);
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    CtrlIn[10:8] = 3'd0;
    step("load_tnew0");
    chk("load_tnew0.tnew_lit", CtrlOut[10:8], 3'd0);

    // Raw-Tnew instance with Tnew=3.
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    CtrlIn[10:8] = 3'd3;
    step("load_tnew3");
    chk("raw_tnew3.tnew_lit", rCtrlOut[10:8], 3'd3);
    chk("dec_tnew3.tnew_lit", CtrlOut[10:8], 3'd2);

    // Three stall cycles with fresh inputs each time.
    begin
`ifdef PIPE_STAGE_STATS_EN
      logic [31:0] s0;
      s0 = StallCnt;
`endif
      for (int i = 0; i < 3; i++) begin
        @(negedge Clk);
        rand_inputs(1'b0, 1'b0, 1'b1);
        step("stall3");
      end
`ifdef PIPE_STAGE_STATS_EN
      chk("stall3.cnt_delta", StallCnt - s0, 32'd3);
`endif
    end

    // Flush keeps PC/BD.
    @(negedge Clk);
    rand_inputs(1'b0, 1'b1, 1'b0);
    PCIn = 32'h0000_3020;
    BDIn = 1'b1;
    step("flush");
    chk("flush.pc_lit",  PCOut, 32'h0000_3020);
    chk("flush.bd_lit",  BDOut, 1'b1);
    chk("flush.ins_lit", InsOut, 32'h0);
    chk("flush.ctrl_lit", CtrlOut, 32'h0);
    chk("flush.valid_lit", ValidOut, 1'b0);

    // Flush together with stall takes the flush.
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    step("reload");
    @(negedge Clk);
    rand_inputs(1'b0, 1'b1, 1'b1);
    step("flush_stall");

    // Req, Flush and Stall together.
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    step("reload2");
    begin
`ifdef PIPE_STAGE_STATS_EN
      logic [31:0] b0;
      b0 = BubbleCnt;
`endif
      @(negedge Clk);
      rand_inputs(1'b1, 1'b1, 1'b1);
      BDIn = 1'b1;
      step("req_all");
      chk("req_all.pc_lit", PCOut, 32'h0000_4180);
      chk("req_all.bd_lit", BDOut, 1'b0);
      chk("req_all.valid_lit", ValidOut, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
      chk("req_all.bubble_delta", BubbleCnt - b0, 32'd1);
`endif
    end

    // Randomized phase.
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      rand_inputs(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) CtrlIn[10:8] = 3'($urandom_range(0, 1));
      step("random");
    end

    // Mid-cycle reset with a valid instruction held.
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    step("pre_midreset");
    chk("pre_midreset.valid_lit", ValidOut, 1'b1);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("midreset");
    chk("midreset.pc_lit", PCOut, 32'h0000_3000);
    @(negedge Clk);
    rand_inputs(1'b1, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    check_all("midreset_held");
    @(negedge Clk);
    Reset = 1'b0;

    // First edges after reset release follow normal priority.
    rand_inputs(1'b0, 1'b0, 1'b1);
    step("post_reset_stall");
    @(negedge Clk);
    rand_inputs(1'b0, 1'b0, 1'b0);
    step("post_reset_load");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
